cache_req_arbiter: RTL and testbench
====================================

# cache_req_arbiter

Two-requester arbiter and sequencer in front of the two-level 4-way cache system (`cache_system_4way`). It accepts read requests from two independent requesters, A and B, and grants them round-robin. Each granted request is driven into the cache system as a one-cycle read pulse. The registered result (data plus L1/L2 hit level) is returned to the granted requester. After an L2 hit, the arbiter holds off the next request for one cycle so the L2→L1 promotion write can complete. It also keeps saturating L1-hit, L2-hit and miss counters for performance monitoring.

## Interface
Parameters:
- ADDR_WIDTH, 11, address width; must match the cache system.
- DATA_WIDTH, 32, data width; must match the cache system.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_a  in  1  requester A read request; held high until gnt_a is seen.
- addr_a  in  ADDR_WIDTH  requester A address; stable while req_a is high.
- req_b  in  1  requester B read request; same rules as A.
- addr_b  in  ADDR_WIDTH  requester B address.
- gnt_a  out  1  one-cycle pulse: A's request has been accepted.
- gnt_b  out  1  one-cycle pulse: B's request has been accepted.
- resp_valid  out  1  one-cycle pulse: response fields are valid.
- resp_id  out  1  owner of the response: 0 = A, 1 = B.
- resp_data  out  DATA_WIDTH  returned read data.
- resp_l1_hit  out  1  the response was an L1 hit.
- resp_l2_hit  out  1  the response was an L2 hit (L1 miss).
- busy  out  1  high in any state other than IDLE.
- cache_addr  out  ADDR_WIDTH  address to the cache system.
- cache_read  out  1  read enable to the cache system.
- cache_read_data  in  DATA_WIDTH  cache system read_data.
- cache_l1_hit  in  1  cache system l1_hit.
- cache_l2_hit  in  1  cache system l2_hit.
- l1_hit_cnt  out  CNT_WIDTH  count of L1 hits.
- l2_hit_cnt  out  CNT_WIDTH  count of L2 hits.
- miss_cnt  out  CNT_WIDTH  count of misses in both levels.

## Operation
- States: IDLE, ISSUE, CAPTURE, PROMOTE.
- IDLE:
  - If either request is high at the clock edge, select a winner, latch its address into cache_addr and its id, pulse the winner's gnt, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: cache_read=1 for exactly this cycle, with cache_addr held. Always go to CAPTURE.
- CAPTURE: cache_read=0. At the end of the cycle:
  - Register cache_read_data, cache_l1_hit and cache_l2_hit into the resp_* fields, and pulse resp_valid.
  - Increment exactly one counter: l1_hit_cnt if l1=1; otherwise l2_hit_cnt if l2=1; otherwise miss_cnt.
  - Go to PROMOTE if cache_l2_hit=1 and cache_l1_hit=0; otherwise go to IDLE.
- PROMOTE: cache_read=0 for one cycle while the L1 fill completes; request inputs are ignored. Always go to IDLE.
- Arbitration:
  - A last-granted pointer is reset to B, so A wins on the first contention.
  - When both requests are high, grant the requester that was not granted last.
  - When only one request is high, grant it regardless of the pointer.
  - The pointer updates on every grant.
- A pending request that loses arbitration keeps req high and is granted on the next IDLE decision. With both requesters continuously requesting, grants strictly alternate.
- Requests are sampled only in IDLE. req is ignored in the other states, including during the gnt cycle.
- Counters saturate at all-ones and never wrap.
- cache_addr holds its last value when idle; cache_read is high only in ISSUE.

## Timing
- Reset (rst_n=0 at an edge):
  - The next state is IDLE.
  - Outputs go to 0: gnt_*, resp_valid, resp_id, resp_data, resp_l*_hit, busy, cache_addr, cache_read, and all counters.
  - The pointer resets to B.
  - An in-flight transaction is dropped with no resp_valid and no counter update.
- Latency, with req sampled at edge E0:
  - gnt and ISSUE occupy cycle 1.
  - CAPTURE occupies cycle 2.
  - resp_valid is high in cycle 3.
- Back-to-back throughput:
  - 3 cycles per request for an L1 hit or a miss.
  - 4 cycles for an L2 hit: the next ISSUE can be no earlier than 2 cycles after resp_valid.
- resp_* fields hold their values after the resp_valid pulse until the next capture.
- gnt_a and gnt_b are never high together; resp_valid is never high in ISSUE.

## Test plan
- Reset, then A requests addr 0x040, and the cache model returns 0x11112222 with l1=1:
  - gnt_a in cycle 1, cache_read=1 with cache_addr=0x040 in cycle 1.
  - resp_valid in cycle 3 with id=0, data=0x11112222, l1=1.
  - l1_hit_cnt=1.
- B requests 0x100, and the model returns a miss with data 0xD00DFEED:
  - resp id=1, data=0xD00DFEED, l1=0, l2=0.
  - miss_cnt=1; the next IDLE is reached right after CAPTURE.
- A requests, and the model returns an L2 hit with 0xCAFEF00D while B is already requesting:
  - A's resp has l2=1 and l2_hit_cnt=1.
  - A PROMOTE cycle with cache_read=0 follows; gnt_b comes 2 cycles after A's resp_valid.
- A and B both hold req continuously for 6 grants: grant order is A,B,A,B,A,B, with resp_id following the same order.
- Assert rst_n=0 during CAPTURE of an A request: no resp_valid, all outputs 0 the next cycle, and after release a B-only request is granted normally.
- Force l1_hit_cnt to all-ones with CNT_WIDTH=4 (15 L1 hits), then one more L1 hit: the counter stays at 15.

Source files
------------

// File: rtl/cache_req_arbiter_if.sv
// ============================================================================
// Module      : cache_req_arbiter_if
// Description : Requester, response, cache-side and statistics signals of the
//               two-requester cache read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cache_req_arbiter_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    // Requester side
    logic                  req_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic                  req_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic                  gnt_a;
    logic                  gnt_b;

    // Response side
    logic                  resp_valid;
    logic                  resp_id;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_l1_hit;
    logic                  resp_l2_hit;
    logic                  busy;

    // Cache system side
    logic [ADDR_WIDTH-1:0] cache_addr;
    logic                  cache_read;
    logic [DATA_WIDTH-1:0] cache_read_data;
    logic                  cache_l1_hit;
    logic                  cache_l2_hit;

    // Statistics
    logic [CNT_WIDTH-1:0]  l1_hit_cnt;
    logic [CNT_WIDTH-1:0]  l2_hit_cnt;
    logic [CNT_WIDTH-1:0]  miss_cnt;

    // The arbiter itself
    modport slave (
        input  req_a, addr_a, req_b, addr_b,
        input  cache_read_data, cache_l1_hit, cache_l2_hit,
        output gnt_a, gnt_b,
        output resp_valid, resp_id, resp_data, resp_l1_hit, resp_l2_hit, busy,
        output cache_addr, cache_read,
        output l1_hit_cnt, l2_hit_cnt, miss_cnt
    );

    // The environment: both requesters plus the cache system
    modport master (
        output req_a, addr_a, req_b, addr_b,
        output cache_read_data, cache_l1_hit, cache_l2_hit,
        input  gnt_a, gnt_b,
        input  resp_valid, resp_id, resp_data, resp_l1_hit, resp_l2_hit, busy,
        input  cache_addr, cache_read,
        input  l1_hit_cnt, l2_hit_cnt, miss_cnt
    );
endinterface

`default_nettype wire

// File: rtl/cache_req_arbiter.sv
// ============================================================================
// Module      : cache_req_arbiter
// Description : Round-robin arbiter/sequencer issuing single-cycle reads from
//               two requesters into a two-level cache, with hit statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_req_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_req_arbiter_if.slave   bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_PROMOTE = 2'd3;

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;

    logic                  r_last_b;
    logic                  r_id;
    logic [ADDR_WIDTH-1:0] r_cache_addr;

    logic                  r_resp_valid;
    logic                  r_resp_id;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic                  r_resp_l1;
    logic                  r_resp_l2;

    logic [CNT_WIDTH-1:0]  r_l1_cnt;
    logic [CNT_WIDTH-1:0]  r_l2_cnt;
    logic [CNT_WIDTH-1:0]  r_miss_cnt;

    logic                  w_any_req;
    logic                  w_pick_b;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_promote;

    logic                  w_gnt_a;
    logic                  w_gnt_b;
    logic                  w_cache_read;
    logic                  w_busy;

    // Under contention B wins only when A was granted last
    assign w_any_req = bus.req_a | bus.req_b;
    assign w_pick_b  = bus.req_b & (~bus.req_a | ~r_last_b);
    assign w_accept  = (r_state == S_IDLE) & w_any_req;
    assign w_capture = (r_state == S_CAPTURE);
    assign w_promote = bus.cache_l2_hit & ~bus.cache_l1_hit;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_any_req) w_next_state = S_ISSUE;
            S_ISSUE:   w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = w_promote ? S_PROMOTE : S_IDLE;
            S_PROMOTE: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_a      = 1'b0;
        w_gnt_b      = 1'b0;
        w_cache_read = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
            end
            S_ISSUE: begin
                // The grant pulse coincides with the read pulse
                w_gnt_a      = ~r_id;
                w_gnt_b      = r_id;
                w_cache_read = 1'b1;
            end
            default: begin
                w_cache_read = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant bookkeeping and cache address
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_b     <= 1'b1;
            r_id         <= 1'b0;
            r_cache_addr <= '0;
        end else if (w_accept) begin
            r_last_b     <= w_pick_b;
            r_id         <= w_pick_b;
            r_cache_addr <= w_pick_b ? bus.addr_b : bus.addr_a;
        end
    end

    // ------------------------------------------------------------------
    // Response capture; fields hold until the next capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_data  <= '0;
            r_resp_l1    <= 1'b0;
            r_resp_l2    <= 1'b0;
        end else begin
            r_resp_valid <= w_capture;
            if (w_capture) begin
                r_resp_id   <= r_id;
                r_resp_data <= bus.cache_read_data;
                r_resp_l1   <= bus.cache_l1_hit;
                r_resp_l2   <= bus.cache_l2_hit;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating statistics; L1 takes precedence if both hit flags are set
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_l1_cnt   <= '0;
            r_l2_cnt   <= '0;
            r_miss_cnt <= '0;
        end else if (w_capture) begin
            if (bus.cache_l1_hit) begin
                if (r_l1_cnt != c_CNT_MAX) r_l1_cnt <= r_l1_cnt + 1'b1;
            end else if (bus.cache_l2_hit) begin
                if (r_l2_cnt != c_CNT_MAX) r_l2_cnt <= r_l2_cnt + 1'b1;
            end else begin
                if (r_miss_cnt != c_CNT_MAX) r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign bus.gnt_a       = w_gnt_a;
    assign bus.gnt_b       = w_gnt_b;
    assign bus.cache_read  = w_cache_read;
    assign bus.busy        = w_busy;
    assign bus.cache_addr  = r_cache_addr;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_id     = r_resp_id;
    assign bus.resp_data   = r_resp_data;
    assign bus.resp_l1_hit = r_resp_l1;
    assign bus.resp_l2_hit = r_resp_l2;
    assign bus.l1_hit_cnt  = r_l1_cnt;
    assign bus.l2_hit_cnt  = r_l2_cnt;
    assign bus.miss_cnt    = r_miss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cache_req_arbiter.sv
// ============================================================================
// Module      : tb_cache_req_arbiter
// Description : Self-checking bench for cache_req_arbiter against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_req_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic rst_n;
    int   cyc;

    int total;
    int bad;

    // Reference model state
    bit m_last_b;
    int m_l1;
    int m_l2;
    int m_miss;
    bit have_prev;
    int prev_resp_cyc;
    bit prev_promote;

    cache_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    cache_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, ".l1_cnt"},   64'(bus.l1_hit_cnt), 64'(sat(m_l1)));
        check({tag, ".l2_cnt"},   64'(bus.l2_hit_cnt), 64'(sat(m_l2)));
        check({tag, ".miss_cnt"}, 64'(bus.miss_cnt),   64'(sat(m_miss)));
    endtask

    task automatic model_reset();
        m_last_b  = 1'b1;
        m_l1      = 0;
        m_l2      = 0;
        m_miss    = 0;
        have_prev = 1'b0;
    endtask

    // One complete transaction starting from IDLE; sa/sb raise a new request
    // unless that requester already has one pending.
    task automatic transact(input bit sa, input bit sb,
                            input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                            input logic [DW-1:0] d, input bit l1, input bit l2);
        bit            win_b;
        bit            promote;
        logic [AW-1:0] exp_addr;
        if (sa && !bus.req_a) begin bus.req_a = 1'b1; bus.addr_a = aa; end
        if (sb && !bus.req_b) begin bus.req_b = 1'b1; bus.addr_b = ab; end
        win_b    = (bus.req_a && bus.req_b) ? !m_last_b : bus.req_b;
        exp_addr = win_b ? bus.addr_b : bus.addr_a;
        m_last_b = win_b;
        promote  = l2 && !l1;

        @(posedge clk); #1;
        check("issue.gnt_a",      64'(bus.gnt_a), 64'(!win_b));
        check("issue.gnt_b",      64'(bus.gnt_b), 64'(win_b));
        check("issue.cache_read", 64'(bus.cache_read), 64'd1);
        check("issue.cache_addr", 64'(bus.cache_addr), 64'(exp_addr));
        check("issue.resp_valid", 64'(bus.resp_valid), 64'd0);
        if (have_prev)
            check("issue.gap", 64'(cyc - prev_resp_cyc), prev_promote ? 64'd2 : 64'd1);
        if (win_b) bus.req_b = 1'b0; else bus.req_a = 1'b0;
        bus.cache_read_data = d;
        bus.cache_l1_hit    = l1;
        bus.cache_l2_hit    = l2;

        @(posedge clk); #1;
        check("capture.cache_read", 64'(bus.cache_read), 64'd0);
        check("capture.gnt",        64'({bus.gnt_a, bus.gnt_b}), 64'd0);
        check("capture.resp_valid", 64'(bus.resp_valid), 64'd0);
        check("capture.busy",       64'(bus.busy), 64'd1);

        @(posedge clk); #1;
        if (l1)      m_l1++;
        else if (l2) m_l2++;
        else         m_miss++;
        check("resp.valid", 64'(bus.resp_valid), 64'd1);
        check("resp.id",    64'(bus.resp_id), 64'(win_b));
        check("resp.data",  64'(bus.resp_data), 64'(d));
        check("resp.l1",    64'(bus.resp_l1_hit), 64'(l1));
        check("resp.l2",    64'(bus.resp_l2_hit), 64'(l2));
        check("resp.busy",  64'(bus.busy), 64'(promote));
        check("resp.cache_read", 64'(bus.cache_read), 64'd0);
        check_counters("resp");
        prev_resp_cyc = cyc;
        prev_promote  = promote;
        have_prev     = 1'b1;
        bus.cache_read_data = ~d;
        bus.cache_l1_hit    = 1'b0;
        bus.cache_l2_hit    = 1'b0;

        if (promote) begin
            @(posedge clk); #1;
            check("promote.resp_valid", 64'(bus.resp_valid), 64'd0);
            check("promote.gnt",        64'({bus.gnt_a, bus.gnt_b}), 64'd0);
            check("promote.busy",       64'(bus.busy), 64'd0);
            check("promote.hold_data",  64'(bus.resp_data), 64'(d));
        end
    endtask

    initial begin
        bit            ra, rb, l1, l2;
        int            kind;
        logic [AW-1:0] xa, xb;
        logic [DW-1:0] xd;

        total = 0;
        bad   = 0;
        bus.req_a = 1'b0; bus.addr_a = '0;
        bus.req_b = 1'b0; bus.addr_b = '0;
        bus.cache_read_data = '0;
        bus.cache_l1_hit = 1'b0;
        bus.cache_l2_hit = 1'b0;
        model_reset();

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy",       64'(bus.busy), 64'd0);
        check("reset.cache_read", 64'(bus.cache_read), 64'd0);
        check("reset.cache_addr", 64'(bus.cache_addr), 64'd0);
        check("reset.resp",       64'({bus.resp_valid, bus.resp_id, bus.resp_l1_hit, bus.resp_l2_hit}), 64'd0);
        check("reset.resp_data",  64'(bus.resp_data), 64'd0);
        check_counters("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed plan
        transact(1, 0, 11'h040, 11'h000, 32'h11112222, 1, 0);
        transact(0, 1, 11'h000, 11'h100, 32'hD00DFEED, 0, 0);
        transact(1, 1, 11'h2A4, 11'h3C8, 32'hCAFEF00D, 0, 1);
        transact(0, 0, 11'h000, 11'h000, 32'h0BADBEEF, 1, 0);

        // Continuous contention: six grants
        for (int i = 0; i < 6; i++)
            transact(1, 1, AW'($urandom), AW'($urandom), $urandom, 1'($urandom_range(0, 1)), 1'b0);

        // Reset during CAPTURE of an A request (A is still pending here)
        bus.req_b = 1'b0;
        @(posedge clk); #1;
        check("rstcap.gnt_a", 64'(bus.gnt_a), 64'd1);
        bus.req_a = 1'b0;
        bus.cache_read_data = 32'h5A5AA5A5;
        bus.cache_l1_hit    = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        model_reset();
        check("rstcap.resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rstcap.busy",       64'(bus.busy), 64'd0);
        check("rstcap.cache_addr", 64'(bus.cache_addr), 64'd0);
        check("rstcap.resp_data",  64'(bus.resp_data), 64'd0);
        check("rstcap.flags",      64'({bus.resp_id, bus.resp_l1_hit, bus.resp_l2_hit, bus.gnt_a, bus.gnt_b, bus.cache_read}), 64'd0);
        check_counters("rstcap");
        rst_n = 1'b1;
        bus.cache_l1_hit = 1'b0;
        transact(0, 1, 11'h000, 11'h155, 32'h600DD00D, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 30; i++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb && !bus.req_a && !bus.req_b) ra = 1'b1;
            xa   = AW'($urandom);
            xb   = AW'($urandom);
            xd   = $urandom;
            kind = $urandom_range(0, 3);
            l1   = (kind == 0) || (kind == 3);
            l2   = (kind == 1) || (kind == 3);
            transact(ra, rb, xa, xb, xd, l1, l2);
        end

        // Drive the L1 counter well past saturation
        for (int i = 0; i < CMAX + 2; i++)
            transact(1, 0, AW'($urandom), 11'h000, $urandom, 1'b1, 1'b0);
        check("sat.l1_cnt", 64'(bus.l1_hit_cnt), 64'(CMAX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
